// File: rtl/gnn_serial_mac_sched.sv
// Serial scheduler for the 4-node, 4-4-2 network: one signed multiplier and one
// accumulator are time-shared across every MAC term of both layers.
module gnn_serial_mac_sched #(
    parameter int DW      = 5,
    parameter int OW      = 21,
    parameter int RELU_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_ready,
    input  logic [16*DW-1:0] x_flat,
    input  logic [16*DW-1:0] w1_flat,
    input  logic [8*DW-1:0]  w2_flat,
    output logic [8*OW-1:0]  out_flat,
    output logic [7:0]       out_ready,
    output logic             busy,
    output logic             done
);
    // Handshake: in_ready is a level request sampled only in IDLE; a run ends in
    // DONE, which is left only once in_ready is seen low, so a held request
    // never starts a second run.
    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t                state;
    logic [16*DW-1:0]      x_q;
    logic [16*DW-1:0]      w1_q;
    logic [8*DW-1:0]       w2_q;
    logic [1:0]            node;
    logic [1:0]            neuron;
    logic [1:0]            term;
    logic signed [OW-1:0]  acc;
    logic signed [11:0]    hid [4];

    logic signed [DW-1:0]  x_sel;
    logic signed [11:0]    op_a;
    logic signed [DW-1:0]  op_b;
    logic signed [11+DW:0] prod;
    logic signed [OW-1:0]  sum;
    logic signed [11:0]    act;

    // Operand mux: layer 1 feeds x (sign-extended to 12 bits), layer 2 feeds hidden values.
    always_comb begin
        x_sel = x_q[32'({node, term}) * DW +: DW];
        op_a  = 12'(x_sel);
        op_b  = w1_q[32'({term, neuron}) * DW +: DW];
        if (state == L2) begin
            op_a = hid[term];
            op_b = w2_q[32'({term, neuron[0]}) * DW +: DW];
        end
        prod = op_a * op_b;
        sum  = acc + OW'(prod);
        act  = sum[11:0];
        if (RELU_EN != 0 && sum[OW-1]) act = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            node      <= '0;
            neuron    <= '0;
            term      <= '0;
            acc       <= '0;
            for (int h = 0; h < 4; h++) hid[h] <= '0;
            out_flat  <= '0;
            out_ready <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready) begin
                        x_q       <= x_flat;
                        w1_q      <= w1_flat;
                        w2_q      <= w2_flat;
                        node      <= '0;
                        neuron    <= '0;
                        term      <= '0;
                        acc       <= '0;
                        out_flat  <= '0;
                        out_ready <= '0;
                        busy      <= 1'b1;
                        state     <= L1;
                    end
                end
                L1: begin
                    term <= term + 2'd1;
                    if (term == 2'd3) begin
                        hid[neuron] <= act;
                        acc         <= '0;
                        neuron      <= neuron + 2'd1;
                        if (neuron == 2'd3) state <= L2;
                    end else begin
                        acc <= sum;
                    end
                end
                L2: begin
                    term <= term + 2'd1;
                    if (term == 2'd3) begin
                        out_flat[32'({node, neuron[0]}) * OW +: OW] <= sum;
                        out_ready[{node, neuron[0]}]                <= 1'b1;
                        acc                                          <= '0;
                        if (neuron == 2'd1) begin
                            neuron <= '0;
                            if (node == 2'd3) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                node  <= node + 2'd1;
                                state <= L1;
                            end
                        end else begin
                            neuron <= neuron + 2'd1;
                        end
                    end else begin
                        acc <= sum;
                    end
                end
                DONE: begin
                    if (!in_ready) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gnn_serial_mac_sched.sv
// Bench for gnn_serial_mac_sched: ReLU and pass-through instances share stimulus;
// a reference model pushes expected outputs that are popped as out_ready bits rise.
module tb_gnn_serial_mac_sched;
    logic         clk;
    logic         rst_n;
    logic         in_ready;
    logic [79:0]  x_flat;
    logic [79:0]  w1_flat;
    logic [39:0]  w2_flat;
    logic [167:0] out_flat, out_flat_nr;
    logic [7:0]   out_ready, out_ready_nr;
    logic         busy, busy_nr, done, done_nr;

    logic [20:0]  exp_q[$];
    logic [20:0]  exp_nr_q[$];
    int           total = 0;
    int           bad = 0;

    gnn_serial_mac_sched #(.DW(5), .OW(21), .RELU_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .x_flat(x_flat),
        .w1_flat(w1_flat), .w2_flat(w2_flat), .out_flat(out_flat),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    gnn_serial_mac_sched #(.DW(5), .OW(21), .RELU_EN(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .x_flat(x_flat),
        .w1_flat(w1_flat), .w2_flat(w2_flat), .out_flat(out_flat_nr),
        .out_ready(out_ready_nr), .busy(busy_nr), .done(done_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] model(input logic [79:0] x, input logic [79:0] w1,
                                          input logic [39:0] w2, input bit relu,
                                          input int n, input int k);
        int hid;
        int acc;
        logic signed [4:0] a;
        logic signed [4:0] b;
        acc = 0;
        for (int h = 0; h < 4; h++) begin
            hid = 0;
            for (int i = 0; i < 4; i++) begin
                a = x[(n*4+i)*5 +: 5];
                b = w1[(i*4+h)*5 +: 5];
                hid += int'(a) * int'(b);
            end
            if (relu && hid < 0) hid = 0;
            b = w2[(h*2+k)*5 +: 5];
            acc += hid * int'(b);
        end
        return acc[20:0];
    endfunction

    task automatic run_job(input logic [79:0] x, input logic [79:0] w1, input logic [39:0] w2,
                           input bit hold, input bit toggle);
        logic [7:0]  prev;
        logic [20:0] e_val;
        logic [95:0] r;
        int          e_edge;
        @(negedge clk);
        x_flat = x; w1_flat = w1; w2_flat = w2; in_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back(model(x, w1, w2, 1'b1, b / 2, b % 2));
            exp_nr_q.push_back(model(x, w1, w2, 1'b0, b / 2, b % 2));
        end
        @(posedge clk); #1;
        prev = 8'h00;
        for (int e = 1; e <= 96; e++) begin
            if (!hold) in_ready = 1'b0;
            if (toggle) begin
                in_ready = (e < 96) ? 1'($urandom_range(0, 1)) : 1'b0;
                r = {$urandom, $urandom, $urandom};
                x_flat = r[79:0]; w1_flat = r[95:16]; w2_flat = r[39:0];
            end
            @(posedge clk); #1;
            if (e == 1) begin
                total++;
                if (out_ready !== 8'h00 || out_flat !== '0 || busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL start_clear: ready=%h out=%h busy=%b done=%b need 00/0/1/0",
                             out_ready, out_flat, busy, done);
                end
            end
            for (int b = 0; b < 8; b++) begin
                if (out_ready[b] && !prev[b]) begin
                    e_edge = 24 * (b / 2) + ((b % 2) ? 24 : 20);
                    total++;
                    if (e !== e_edge) begin
                        bad++;
                        $display("FAIL ready_edge[%0d]: got E%0d need E%0d", b, e, e_edge);
                    end
                    total++;
                    if (exp_q.size() == 0 || exp_nr_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_underflow[%0d]: got empty queue need entry", b);
                    end else begin
                        e_val = exp_q.pop_front();
                        if (out_flat[b*21 +: 21] !== e_val) begin
                            bad++;
                            $display("FAIL out_relu[%0d]: got %h need %h", b, out_flat[b*21 +: 21], e_val);
                        end
                        e_val = exp_nr_q.pop_front();
                        if (out_flat_nr[b*21 +: 21] !== e_val || out_ready_nr[b] !== 1'b1) begin
                            bad++;
                            $display("FAIL out_pass[%0d]: got %h need %h", b, out_flat_nr[b*21 +: 21], e_val);
                        end
                    end
                end
            end
            prev = out_ready;
            if (e == 95) begin
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL e95_state: busy=%b done=%b need 1/0", busy, done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_ready !== 8'hFF || done_nr !== 1'b1 || busy_nr !== 1'b0) begin
            bad++;
            $display("FAIL e96_done: busy=%b done=%b ready=%h need 0/1/ff", busy, done, out_ready);
        end
        total++;
        if (exp_q.size() != 0 || exp_nr_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d/%0d entries need 0", exp_q.size(), exp_nr_q.size());
            exp_q.delete(); exp_nr_q.delete();
        end
        if (!hold) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_exit: busy=%b done=%b need 0/0", busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_ready = 1'b0;
        x_flat = '0; w1_flat = '0; w2_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_flat !== '0 || out_ready !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out=%h ready=%h busy=%b done=%b need 0", out_flat, out_ready, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b done=%b need 0/0", busy, done);
        end
    endtask

    task automatic test_max();
        run_job({16{5'b01111}}, {16{5'b01111}}, {8{5'b01111}}, 1'b1, 1'b0);
        total++;
        if (out_flat[0 +: 21] !== 21'd54000 || out_flat[147 +: 21] !== 21'd54000) begin
            bad++;
            $display("FAIL max_value: got %h need %h", out_flat[0 +: 21], 21'd54000);
        end
        // in_ready still high: must stay in DONE without a new run
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_ready !== 8'hFF) begin
            bad++;
            $display("FAIL held_no_rerun: busy=%b done=%b ready=%h need 0/1/ff", busy, done, out_ready);
        end
        @(negedge clk); in_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL max_release: busy=%b done=%b need 0/0", busy, done);
        end
    endtask

    task automatic test_min();
        run_job({16{5'b10000}}, {16{5'b10000}}, {8{5'b10000}}, 1'b0, 1'b0);
        total++;
        if (out_flat[21 +: 21] !== 21'h1F0000 || out_flat_nr[84 +: 21] !== 21'h1F0000) begin
            bad++;
            $display("FAIL min_value: got %h need %h", out_flat[21 +: 21], 21'h1F0000);
        end
    endtask

    task automatic test_relu();
        run_job({16{5'b00001}}, {16{5'b11111}}, {8{5'b00001}}, 1'b0, 1'b0);
        total++;
        if (out_flat !== '0 || out_flat_nr[0 +: 21] !== 21'h1FFFF0 || out_flat_nr[63 +: 21] !== 21'h1FFFF0) begin
            bad++;
            $display("FAIL relu_value: got %h/%h need 0/1ffff0", out_flat[0 +: 21], out_flat_nr[0 +: 21]);
        end
    endtask

    task automatic test_reset_mid();
        logic [95:0] r;
        @(negedge clk);
        x_flat = {16{5'b00111}}; w1_flat = {16{5'b00011}}; w2_flat = {8{5'b00010}}; in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_ready !== 8'h00 || out_flat !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: ready=%h out=%h busy=%b need 0", out_ready, out_flat, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        r = {$urandom, $urandom, $urandom};
        run_job(r[79:0], r[95:16], r[39:0], 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [95:0] r;
        for (int j = 0; j < 3; j++) begin
            r = {$urandom, $urandom, $urandom};
            run_job(r[79:0], r[91:12], r[47:8], 1'b0, j != 1);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_min();
        test_relu();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
